// File: rtl/tank_access_sequencer.sv
// Purpose : one store request -> one-hot in/out/clr tank selects, timed to the rotating tank position.
// Latency : selects open on the addressed digit/word (>= 2 cycles after req), ack one cycle after the last select cycle.
// Backpressure: req is sampled only while idle; requests arriving while busy are dropped.
// Build option: define LONG_WORD_EN to honour long_wd (full-word transfers); otherwise every transfer is a half word.
module tank_access_sequencer #(
  parameter int NUM_RACKS      = 4,
  parameter int TANKS_PER_RACK = 8,
  parameter int WORDS_PER_TANK = 16,
  parameter int WORD_DIGITS    = 36,
  localparam int NT = NUM_RACKS * TANKS_PER_RACK,
  localparam int RW = (NUM_RACKS > 1) ? $clog2(NUM_RACKS) : 1,
  localparam int TW = (TANKS_PER_RACK > 1) ? $clog2(TANKS_PER_RACK) : 1,
  localparam int WW = (WORDS_PER_TANK > 1) ? $clog2(WORDS_PER_TANK) : 1,
  localparam int DW = (WORD_DIGITS > 1) ? $clog2(WORD_DIGITS) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req,
  input  logic          wr,
  input  logic [RW-1:0] rack_sel,
  input  logic [TW-1:0] tank_sel,
  input  logic [WW-1:0] word_sel,
  input  logic          half_sel,
  input  logic          long_wd,
  input  logic          mib,
  input  logic [NT-1:0] tank_mob,
  output logic [NT-1:0] tank_in,
  output logic [NT-1:0] tank_clr,
  output logic [NT-1:0] tank_out,
  output logic          mob,
  output logic [DW-1:0] digit,
  output logic [WW-1:0] word,
  output logic          busy,
  output logic          ack,
  output logic          err
);

  localparam int HALF = WORD_DIGITS / 2;
  localparam int IW   = (NT > 1) ? $clog2(NT) : 1;

`ifdef LONG_WORD_EN
  localparam logic LONG_EN = 1'b1;
`else
  localparam logic LONG_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    XFER = 2'd2,
    DONE = 2'd3
  } state_t;

  // Free-running tank position.
  logic [DW-1:0] digit_q, digit_d;
  logic [WW-1:0] word_q, word_d;

  // Request fields latched at accept.
  state_t        state_q;
  logic          wr_l_q;
  logic [RW-1:0] rack_l_q;
  logic [TW-1:0] tank_l_q;
  logic [WW-1:0] word_l_q;
  logic          half_l_q;
  logic          long_l_q;
  logic          first_q;
  logic [DW-1:0] cnt_q;

  // Registered outputs.
  logic [NT-1:0] tank_in_q, tank_clr_q, tank_out_q;
  logic          busy_q, ack_q, err_q;

  logic [DW-1:0] start_dig;
  logic [DW-1:0] last_cnt;
  logic [IW-1:0] sel_idx;
  logic [NT-1:0] sel_oh;
  logic          range_ok;
  logic          pos_match;

  // Write data goes from main control straight to the rack write gates; the
  // port is kept so the sequencer drops into the old decode path unchanged.
  logic unused_mib;
  assign unused_mib = mib;

  // Next tank position: digit wraps every word time, word wraps every circulation.
  always_comb begin
    digit_d = digit_q + 1'b1;
    word_d  = word_q;
    if (digit_q == DW'(WORD_DIGITS - 1)) begin
      digit_d = '0;
      word_d  = (word_q == WW'(WORDS_PER_TANK - 1)) ? '0 : word_q + 1'b1;
    end
  end

  // Position counters run regardless of the sequencer state.
  always_ff @(posedge clk) begin
    if (reset) begin
      digit_q <= '0;
      word_q  <= '0;
    end else begin
      digit_q <= digit_d;
      word_q  <= word_d;
    end
  end

  // Transfer window and target tank derived from the latched request.
  assign start_dig = (!long_l_q && half_l_q) ? DW'(HALF) : '0;
  assign last_cnt  = long_l_q ? DW'(WORD_DIGITS - 1) : DW'(HALF - 1);
  assign range_ok  = (int'(rack_l_q) < NUM_RACKS) && (int'(tank_l_q) < TANKS_PER_RACK);
  assign sel_idx   = IW'(int'(rack_l_q) * TANKS_PER_RACK + int'(tank_l_q));
  assign sel_oh    = NT'(1) << sel_idx;
  // Compare against the next position so the registered selects rise exactly
  // on the start digit.
  assign pos_match = (digit_d == start_dig) && (word_d == word_l_q);

  // Sequencer: accept, wait for the word to come round, gate it for one window, acknowledge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      wr_l_q     <= 1'b0;
      rack_l_q   <= '0;
      tank_l_q   <= '0;
      word_l_q   <= '0;
      half_l_q   <= 1'b0;
      long_l_q   <= 1'b0;
      first_q    <= 1'b0;
      cnt_q      <= '0;
      tank_in_q  <= '0;
      tank_clr_q <= '0;
      tank_out_q <= '0;
      busy_q     <= 1'b0;
      ack_q      <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          ack_q <= 1'b0;
          err_q <= 1'b0;
          if (req) begin
            wr_l_q   <= wr;
            rack_l_q <= rack_sel;
            tank_l_q <= tank_sel;
            word_l_q <= word_sel;
            half_l_q <= half_sel;
            long_l_q <= long_wd & LONG_EN;
            first_q  <= 1'b1;
            busy_q   <= 1'b1;
            state_q  <= WAIT;
          end
        end
        WAIT: begin
          first_q <= 1'b0;
          if (first_q && !range_ok) begin
            err_q   <= 1'b1;
            ack_q   <= 1'b1;
            state_q <= DONE;
          end else if (pos_match) begin
            cnt_q <= '0;
            if (wr_l_q) begin
              tank_in_q  <= sel_oh;
              tank_clr_q <= sel_oh;
            end else begin
              tank_out_q <= sel_oh;
            end
            state_q <= XFER;
          end
        end
        XFER: begin
          if (cnt_q == last_cnt) begin
            tank_in_q  <= '0;
            tank_clr_q <= '0;
            tank_out_q <= '0;
            ack_q      <= 1'b1;
            state_q    <= DONE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        DONE: begin
          ack_q   <= 1'b0;
          err_q   <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign tank_in  = tank_in_q;
  assign tank_clr = tank_clr_q;
  assign tank_out = tank_out_q;
  assign mob      = |(tank_mob & tank_out_q);
  assign digit    = digit_q;
  assign word     = word_q;
  assign busy     = busy_q;
  assign ack      = ack_q;
  assign err      = err_q;

endmodule

// File: tb/tb_tank_access_sequencer.sv
// Bench for tank_access_sequencer: directed scenario table plus randomized traffic
// compared every cycle against a timeline model (absolute cycle arithmetic).
// Three racks are used so that an out-of-range rack index fits in the 2-bit field.
module tb_tank_access_sequencer;

  localparam int NR   = 3;
  localparam int TPR  = 8;
  localparam int WPT  = 16;
  localparam int D    = 36;
  localparam int NT   = NR * TPR;
  localparam int RW   = 2;
  localparam int TW   = 3;
  localparam int WW   = 4;
  localparam int DW   = 6;
  localparam int C    = D * WPT;
  localparam int HALF = D / 2;
`ifdef LONG_WORD_EN
  localparam bit LONG_EN = 1'b1;
`else
  localparam bit LONG_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          req, wr, half_sel, long_wd, mib;
  logic [RW-1:0] rack_sel;
  logic [TW-1:0] tank_sel;
  logic [WW-1:0] word_sel;
  logic [NT-1:0] tank_mob;
  logic [NT-1:0] tank_in, tank_clr, tank_out;
  logic          mob, busy, ack, err;
  logic [DW-1:0] digit;
  logic [WW-1:0] word;

  tank_access_sequencer #(
    .NUM_RACKS(NR), .TANKS_PER_RACK(TPR), .WORDS_PER_TANK(WPT), .WORD_DIGITS(D)
  ) dut (
    .clk(clk), .reset(reset), .req(req), .wr(wr), .rack_sel(rack_sel),
    .tank_sel(tank_sel), .word_sel(word_sel), .half_sel(half_sel), .long_wd(long_wd),
    .mib(mib), .tank_mob(tank_mob), .tank_in(tank_in), .tank_clr(tank_clr),
    .tank_out(tank_out), .mob(mob), .digit(digit), .word(word), .busy(busy),
    .ack(ack), .err(err)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  // Timeline model: t = cycles since the last reset edge.
  int t = 0;
  bit mvalid = 1'b0;
  bit act = 1'b0;
  int ta, ts, tack, m_len, m_idx;
  bit m_wr, m_err;

  // Observation of the current directed request.
  int   obs_len, obs_acks, obs_first_t, obs_first_d, obs_first_w, obs_ack_d, obs_ack_w;
  logic obs_err;
  logic [NT-1:0] obs_in, obs_clr, obs_out;

  typedef struct {
    bit wr; int rack; int tank; int word; bit half; bit lng;
    int at_word; int at_digit;
    bit exp_err; int exp_idx; int exp_first_d; int exp_first_w; int exp_len;
    int exp_ack_d; int exp_ack_w; int exp_wait;
  } vec_t;

  function automatic bit idle_at(int tt);
    return !act || tt > tack;
  endfunction

  task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
    n_chk++;
    if (a === e) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0d)", nm, a, e, t);
  endtask

  task automatic fail_now(input string nm);
    n_chk++;
    $display("FAIL %s: timed out (t=%0d)", nm, t);
  endtask

  task automatic obs_clear();
    obs_len = 0; obs_acks = 0; obs_first_t = -1; obs_first_d = -1; obs_first_w = -1;
    obs_ack_d = -1; obs_ack_w = -1; obs_err = 1'b0;
    obs_in = '0; obs_clr = '0; obs_out = '0;
  endtask

  task automatic check_cycle();
    logic [NT-1:0] oh, e_in, e_out;
    bit win, e_mob, e_ack;
    oh = '0;
    if (act && !m_err) oh[m_idx] = 1'b1;
    win   = act && !m_err && t >= ts && t < ts + m_len;
    e_in  = (win && m_wr) ? oh : '0;
    e_out = (win && !m_wr) ? oh : '0;
    e_mob = win && !m_wr && tank_mob[m_idx];
    e_ack = act && t == tack;
    chk("tank_in",  64'(tank_in),  64'(e_in));
    chk("tank_clr", 64'(tank_clr), 64'(e_in));
    chk("tank_out", 64'(tank_out), 64'(e_out));
    chk("mob",      64'(mob),      64'(e_mob));
    chk("digit",    64'(digit),    64'(t % D));
    chk("word",     64'(word),     64'((t / D) % WPT));
    chk("busy",     64'(busy),     64'(act && t > ta && t <= tack));
    chk("ack",      64'(ack),      64'(e_ack));
    chk("err",      64'(err),      64'(e_ack && m_err));
    if ((tank_in | tank_out) != '0) begin
      if (obs_len == 0) begin
        obs_first_t = t; obs_first_d = int'(digit); obs_first_w = int'(word);
        obs_in = tank_in; obs_clr = tank_clr; obs_out = tank_out;
      end
      obs_len++;
    end
    if (ack === 1'b1) begin
      obs_acks++; obs_ack_d = int'(digit); obs_ack_w = int'(word); obs_err = err;
    end
  endtask

  task automatic model_step();
    bit lng;
    int start, p, e;
    if (reset) begin
      t = 0; act = 1'b0; mvalid = 1'b1;
    end else begin
      if (req && idle_at(t)) begin
        ta    = t;
        m_wr  = wr;
        m_err = (int'(rack_sel) >= NR) || (int'(tank_sel) >= TPR);
        lng   = long_wd && LONG_EN;
        start = lng ? 0 : (half_sel ? HALF : 0);
        m_len = lng ? D : HALF;
        p     = int'(word_sel) * D + start;
        e     = ta + 2;
        ts    = e + (((p - e) % C) + C) % C;
        tack  = m_err ? ta + 2 : ts + m_len;
        m_idx = int'(rack_sel) * TPR + int'(tank_sel);
        act   = 1'b1;
      end
      t++;
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    tank_mob = NT'($urandom);
    mib      = 1'($urandom);
    #1;
    if (mvalid) check_cycle();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic issue(input vec_t v, input string nm, output int treq);
    int guard = 0;
    while (!(idle_at(t) && (t % D) == v.at_digit && ((t / D) % WPT) == v.at_word)
           && guard < 3 * C) begin
      cycle();
      guard++;
    end
    if (guard >= 3 * C) fail_now({nm, "_sync"});
    wr = v.wr; rack_sel = RW'(v.rack); tank_sel = TW'(v.tank); word_sel = WW'(v.word);
    half_sel = v.half; long_wd = v.lng;
    obs_clear();
    treq = t;
    req = 1'b1;
    cycle();
    req = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input string nm);
    int treq;
    int guard = 0;
    logic [NT-1:0] oh;
    issue(v, nm, treq);
    while (obs_acks == 0 && guard < 3 * C) begin
      cycle();
      guard++;
    end
    if (guard >= 3 * C) fail_now({nm, "_ack"});
    cycle();
    chk({nm, "_acks"},  64'(obs_acks),  64'(1));
    chk({nm, "_err"},   64'(obs_err),   64'(v.exp_err));
    chk({nm, "_len"},   64'(obs_len),   64'(v.exp_len));
    chk({nm, "_ack_d"}, 64'(obs_ack_d), 64'(v.exp_ack_d));
    chk({nm, "_ack_w"}, 64'(obs_ack_w), 64'(v.exp_ack_w));
    if (!v.exp_err) begin
      oh = '0;
      oh[v.exp_idx] = 1'b1;
      chk({nm, "_first_d"}, 64'(obs_first_d), 64'(v.exp_first_d));
      chk({nm, "_first_w"}, 64'(obs_first_w), 64'(v.exp_first_w));
      chk({nm, "_in"},  64'(obs_in),  64'(v.wr ? oh : '0));
      chk({nm, "_clr"}, 64'(obs_clr), 64'(v.wr ? oh : '0));
      chk({nm, "_out"}, 64'(obs_out), 64'(v.wr ? '0 : oh));
      chk({nm, "_wait"}, 64'(obs_first_t - treq), 64'(v.exp_wait));
    end
  endtask

  vec_t tab[6];

  initial begin
    int treq;
    int guard;
    vec_t v6;

    //         wr rack tank word half lng @word @dig  err idx f_d f_w len ack_d ack_w wait
    tab[0] = '{0, 0,   0,   3,   0,   0,  0,    5,    0,  0,  0,  3,  18, 18,   3,    103};
    tab[1] = '{1, 2,   5,   15,  1,   0,  4,    10,   0,  21, 18, 15, 18, 0,    0,    404};
    tab[2] = '{0, 1,   2,   7,   0,   0,  7,    0,    0,  10, 0,  7,  18, 18,   7,    576};
    tab[3] = '{1, 3,   0,   5,   0,   0,  2,    0,    1,  0,  0,  0,  0,  2,    2,    0};
`ifdef LONG_WORD_EN
    tab[4] = '{1, 1,   7,   9,   1,   1,  8,    30,   0,  15, 0,  9,  36, 0,    10,   6};
`else
    tab[4] = '{1, 1,   7,   9,   1,   1,  8,    30,   0,  15, 18, 9,  18, 0,    10,   24};
`endif
    tab[5] = '{0, 2,   7,   0,   1,   0,  15,   20,   0,  23, 18, 0,  18, 0,    1,    34};

    reset = 1'b1; req = 1'b0; wr = 1'b0; rack_sel = '0; tank_sel = '0; word_sel = '0;
    half_sel = 1'b0; long_wd = 1'b0; mib = 1'b0; tank_mob = '0;
    obs_clear();
    cycle();
    cycle();
    chk("rst_digit", 64'(digit), 64'(0));
    chk("rst_word",  64'(word),  64'(0));
    chk("rst_sel",   64'(tank_in | tank_clr | tank_out), 64'(0));
    chk("rst_busy",  64'(busy),  64'(0));
    chk("rst_ack",   64'(ack),   64'(0));
    reset = 1'b0;

    for (int i = 0; i < 6; i++) run_vec(tab[i], $sformatf("vec%0d", i));

    // Reset in the middle of a write transfer.
    v6 = '{1, 0, 3, 1, 0, 0, 0, 0, 0, 3, 0, 1, 18, 18, 1, 36};
    issue(v6, "midrst", treq);
    guard = 0;
    while (obs_len < 5 && guard < 3 * C) begin
      cycle();
      guard++;
    end
    if (guard >= 3 * C) fail_now("midrst_start");
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    chk("midrst_in",    64'(tank_in),  64'(0));
    chk("midrst_clr",   64'(tank_clr), 64'(0));
    chk("midrst_busy",  64'(busy),     64'(0));
    chk("midrst_digit", 64'(digit),    64'(0));
    for (int i = 0; i < 60; i++) cycle();
    chk("midrst_noack", 64'(obs_acks), 64'(0));
    run_vec(tab[0], "postrst");

    // Randomized traffic, including requests while busy and rare resets.
    for (int i = 0; i < 14000; i++) begin
      reset    = ($urandom_range(0, 2999) == 0);
      req      = ($urandom_range(0, 7) == 0);
      wr       = 1'($urandom);
      rack_sel = RW'($urandom);
      tank_sel = TW'($urandom);
      word_sel = WW'($urandom);
      half_sel = 1'($urandom);
      long_wd  = 1'($urandom);
      cycle();
    end
    reset = 1'b0;
    req   = 1'b0;
    cycle();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
